skin_map_reader: RTL and testbench

SKIN_MAP_READER -- requirements
Module: skin_map_reader

---
 rtl/skin_map_reader_if.sv | 59 +++++
 rtl/skin_map_reader.sv | 188 ++++++++++++++++++
 tb/tb_skin_map_reader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/skin_map_reader_if.sv
// Skin-map reader bus: frame request, skin-map RAM read port, output stream and frame status.
// Latency: none (signal bundle only).
// Backpressure: the output stream is valid/ready (oValid/iReady); the RAM port has no stall.
//
// Ports (master = reader, slave = environment):
//   iStart       frame request pulse
//   oAddr_SM     skin-map read address
//   oRdreq_SM    skin-map read enable
//   iData_SM     read data, valid one cycle after oRdreq_SM
//   oValid       output skin bit available
//   iReady       downstream accepts the skin bit this cycle
//   oData        skin bit (1 = skin pixel)
//   oLast        marks the entry at address DEPTH-1
//   oBusy        frame read in progress
//   oSkin_count  skin bits transferred in the last completed frame
//   oDone        one-cycle pulse on frame completion
interface skin_map_reader_if #(
    parameter int ADDR_W = 13
);
    logic              iStart;
    logic [ADDR_W-1:0] oAddr_SM;
    logic              oRdreq_SM;
    logic              iData_SM;
    logic              oValid;
    logic              iReady;
    logic              oData;
    logic              oLast;
    logic              oBusy;
    logic [ADDR_W:0]   oSkin_count;
    logic              oDone;

    modport master (
        input  iStart,
        output oAddr_SM,
        output oRdreq_SM,
        input  iData_SM,
        output oValid,
        input  iReady,
        output oData,
        output oLast,
        output oBusy,
        output oSkin_count,
        output oDone
    );

    modport slave (
        output iStart,
        input  oAddr_SM,
        input  oRdreq_SM,
        output iData_SM,
        input  oValid,
        output iReady,
        input  oData,
        input  oLast,
        input  oBusy,
        input  oSkin_count,
        input  oDone
    );
endinterface

// File: rtl/skin_map_reader.sv
// Reads one full frame of the skin map (addresses 0..DEPTH-1) and streams the bits out, counting skin pixels.
// Latency: start accepted at edge 0 -> first read in the next cycle -> first oValid after edge 2; then 1 bit/cycle.
// Backpressure: iReady low stalls the stream; reads are throttled so buffered + in-flight bits never exceed 2.
//
// Ports:
//   iClk    sole clock, rising edge
//   iReset  asynchronous, active-high reset
//   bus     skin_map_reader_if master modport (see interface file for the signal list)
module skin_map_reader #(
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = 13
) (
    input  logic               iClk,
    input  logic               iReset,
    skin_map_reader_if.master  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              inflight_q;
    logic              inflight_last_q;

    // Two-entry output buffer; each entry carries the skin bit and its last flag.
    logic [1:0]        fifo_dat;
    logic [1:0]        fifo_lst;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    logic [ADDR_W:0]   skin_cnt_q;
    logic [ADDR_W:0]   skin_count_q;
    logic              done_q;

    logic              start_acc;
    logic              fifo_vld;
    logic              head_dat;
    logic              head_lst;
    logic              push;
    logic              pop;
    logic [1:0]        credit_used;
    logic              issue;
    logic              last_issue;
    logic              frame_end;

    assign start_acc = (state_q == IDLE) && bus.iStart;

    assign fifo_vld  = (fifo_cnt != 2'd0);
    assign head_dat  = fifo_dat[rd_ptr];
    assign head_lst  = fifo_lst[rd_ptr];

    // Data returned by the RAM always lands in the buffer the cycle it appears.
    assign push      = inflight_q;
    assign pop       = fifo_vld && bus.iReady;
    assign frame_end = pop && head_lst;

    // Slots committed after this edge: buffered + in flight, minus the entry leaving now.
    // Counting the departing entry lets reads continue back-to-back while the
    // consumer keeps up, yet the buffer can never be asked to hold a third bit.
    assign credit_used = fifo_cnt + {1'b0, inflight_q} - {1'b0, pop};

    assign issue      = (state_q == READ) && (credit_used < 2'd2);
    assign last_issue = issue && (addr_q == LAST_ADDR);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    state_d = READ;
                end
            end
            READ: begin
                // Leave once the final address has been issued; its data drains afterwards.
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (frame_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read address generator and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= last_issue;
            if (start_acc) begin
                addr_q <= '0;
            end else if (issue) begin
                // Wrap to 0 after the last address so the idle address reads 0.
                addr_q <= last_issue ? '0 : addr_q + ADDR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            fifo_dat <= '0;
            fifo_lst <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_dat[wr_ptr] <= bus.iData_SM;
                fifo_lst[wr_ptr] <= inflight_last_q;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // ------------------------------------------------------------------
    // Skin counting and frame completion
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            skin_cnt_q   <= '0;
            skin_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (start_acc) begin
                skin_cnt_q <= '0;
            end else if (pop && head_dat) begin
                skin_cnt_q <= skin_cnt_q + (ADDR_W+1)'(1);
            end
            // The final transfer is folded in here, so the published count is
            // complete in the same cycle the done pulse appears.
            if (frame_end) begin
                skin_count_q <= skin_cnt_q + (ADDR_W+1)'(head_dat);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.oAddr_SM    = addr_q;
    assign bus.oRdreq_SM   = issue;
    assign bus.oValid      = fifo_vld;
    assign bus.oData       = fifo_vld && head_dat;
    assign bus.oLast       = fifo_vld && head_lst;
    assign bus.oBusy       = (state_q != IDLE);
    assign bus.oSkin_count = skin_count_q;
    assign bus.oDone       = done_q;

endmodule

// File: tb/tb_skin_map_reader.sv
// Directed bench for skin_map_reader: synchronous RAM model, per-cycle stream checks, frame-level checks.
// Latency: n/a (testbench).
// Backpressure: iReady driven high or 50% random per frame.
module tb_skin_map_reader;

    localparam int DEPTH  = 8192;
    localparam int ADDR_W = 13;

    logic iClk = 1'b0;
    logic iReset;

    skin_map_reader_if #(.ADDR_W(ADDR_W)) bus ();

    skin_map_reader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClk = ~iClk;

    // Skin-map RAM model: registered read, junk returned when not enabled.
    logic map_bits [0:DEPTH-1];

    always @(posedge iClk) begin
        if (bus.oRdreq_SM) begin
            bus.iData_SM <= map_bits[bus.oAddr_SM];
        end else begin
            bus.iData_SM <= 1'($urandom_range(0, 1));
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model / bookkeeping
    int   exp_addr, exp_idx, issued, xfers, done_cnt, cyc;
    int   first_xfer_cyc, last_xfer_cyc, done_cyc;
    logic prev_valid, prev_ready, prev_data, prev_last;
    logic s_xfer, s_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic new_frame_model();
        exp_addr       = 0;
        exp_idx        = 0;
        issued         = 0;
        xfers          = 0;
        done_cnt       = 0;
        first_xfer_cyc = -1;
        last_xfer_cyc  = -1;
        done_cyc       = -1;
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_addr"},   32'(bus.oAddr_SM),    0);
        chk({p, "_rdreq"},  32'(bus.oRdreq_SM),   0);
        chk({p, "_valid"},  32'(bus.oValid),      0);
        chk({p, "_data"},   32'(bus.oData),       0);
        chk({p, "_last"},   32'(bus.oLast),       0);
        chk({p, "_busy"},   32'(bus.oBusy),       0);
        chk({p, "_skin"},   32'(bus.oSkin_count), 0);
        chk({p, "_done"},   32'(bus.oDone),       0);
    endtask

    // One clock cycle: drive inputs after the falling edge, then check what the DUT shows.
    task automatic cycle(input logic start, input logic ready);
        @(negedge iClk);
        bus.iStart = start;
        bus.iReady = ready;
        #1;
        cyc++;
        if (prev_valid && !prev_ready) begin
            chk("hold_valid", 32'(bus.oValid), 1);
            chk("hold_data",  32'(bus.oData),  32'(prev_data));
            chk("hold_last",  32'(bus.oLast),  32'(prev_last));
        end
        if (bus.oRdreq_SM) begin
            chk("rd_addr", 32'(bus.oAddr_SM), 32'(exp_addr));
            exp_addr++;
            issued++;
        end
        s_xfer = bus.oValid && ready;
        s_last = bus.oLast;
        if (s_xfer) begin
            if (exp_idx < DEPTH) begin
                chk("out_data", 32'(bus.oData), 32'(map_bits[exp_idx]));
                chk("out_last", 32'(bus.oLast), 32'(exp_idx == DEPTH - 1));
            end else begin
                chk("xfer_index", 32'(exp_idx), DEPTH - 1);
            end
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            exp_idx++;
            xfers++;
        end
        chk("outstanding_le2", 32'((issued - xfers) <= 2), 1);
        if (bus.oDone) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_valid = bus.oValid;
        prev_ready = ready;
        prev_data  = bus.oData;
        prev_last  = bus.oLast;
    endtask

    // Run until oDone (bounded). Optional stray iStart after N transfers and
    // optional iStart in the oDone cycle (the cycle after the last transfer).
    task automatic run_to_done(input logic rand_ready, input int mid_start_at, input logic chain);
        logic got;
        logic mid_done;
        logic last_prev;
        logic start;
        logic ready;
        got       = 1'b0;
        mid_done  = 1'b0;
        last_prev = 1'b0;
        for (int n = 0; n < 20000 && !got; n++) begin
            start = 1'b0;
            if (mid_start_at >= 0 && !mid_done && xfers == mid_start_at) begin
                start    = 1'b1;
                mid_done = 1'b1;
            end
            if (chain && last_prev) start = 1'b1;
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle(start, ready);
            last_prev = s_xfer && s_last;
            if (bus.oDone) got = 1'b1;
        end
        chk("done_seen", 32'(got), 1);
    endtask

    function automatic int popcount_map();
        int pc = 0;
        for (int i = 0; i < DEPTH; i++) pc += int'(map_bits[i]);
        return pc;
    endfunction

    initial begin
        int pc;
        cyc        = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = 1'b0;
        prev_last  = 1'b0;
        s_xfer     = 1'b0;
        s_last     = 1'b0;
        new_frame_model();

        // ---- Power-on reset ----
        iReset     = 1'b1;
        bus.iStart = 1'b0;
        bus.iReady = 1'b0;
        #3;
        chk_all_zero("por");
        repeat (2) @(negedge iClk);
        iReset = 1'b0;
        repeat (3) begin
            cycle(1'b0, 1'b1);
            chk("idle_valid", 32'(bus.oValid),    0);
            chk("idle_rdreq", 32'(bus.oRdreq_SM), 0);
        end

        // ---- Frame A: alternating 1,0 map, iReady high, latency and throughput ----
        for (int i = 0; i < DEPTH; i++) map_bits[i] = (i % 2 == 0);
        new_frame_model();
        cycle(1'b1, 1'b1);
        chk("a_busy_pre", 32'(bus.oBusy),     0);
        cycle(1'b0, 1'b1);
        chk("a_rdreq_c1", 32'(bus.oRdreq_SM), 1);
        chk("a_addr_c1",  32'(bus.oAddr_SM),  0);
        chk("a_busy_c1",  32'(bus.oBusy),     1);
        chk("a_valid_c1", 32'(bus.oValid),    0);
        cycle(1'b0, 1'b1);
        chk("a_valid_c2", 32'(bus.oValid),    0);
        cycle(1'b0, 1'b1);
        chk("a_valid_c3", 32'(bus.oValid),    1);
        chk("a_data_c3",  32'(bus.oData),     1);
        run_to_done(1'b0, -1, 1'b0);
        chk("a_xfers",      32'(xfers),                         DEPTH);
        chk("a_issued",     32'(issued),                        DEPTH);
        chk("a_span",       32'(last_xfer_cyc - first_xfer_cyc), DEPTH - 1);
        chk("a_done_after", 32'(done_cyc - last_xfer_cyc),       1);
        chk("a_done_cnt",   32'(done_cnt),                      1);
        chk("a_skin",       32'(bus.oSkin_count),               4096);
        chk("a_busy_done",  32'(bus.oBusy),                     0);
        cycle(1'b0, 1'b1);
        chk("a_done_pulse", 32'(bus.oDone),       0);
        chk("a_skin_hold",  32'(bus.oSkin_count), 4096);
        chk("a_idle_rdreq", 32'(bus.oRdreq_SM),   0);

        // ---- Frame B: all zeros, stray iStart after transfer 100, chained start in oDone cycle ----
        for (int i = 0; i < DEPTH; i++) map_bits[i] = 1'b0;
        new_frame_model();
        cycle(1'b1, 1'b1);
        run_to_done(1'b0, 100, 1'b1);
        chk("b_xfers",    32'(xfers),            DEPTH);
        chk("b_done_cnt", 32'(done_cnt),         1);
        chk("b_skin",     32'(bus.oSkin_count),  0);
        chk("b_busy",     32'(bus.oBusy),        0);

        // ---- Frame C: all ones, started in the oDone cycle of frame B ----
        for (int i = 0; i < DEPTH; i++) map_bits[i] = 1'b1;
        new_frame_model();
        cycle(1'b0, 1'b1);
        chk("c_rdreq_first", 32'(bus.oRdreq_SM), 1);
        chk("c_addr_first",  32'(bus.oAddr_SM),  0);
        chk("c_busy_first",  32'(bus.oBusy),     1);
        chk("c_skin_prev",   32'(bus.oSkin_count), 0);
        run_to_done(1'b0, -1, 1'b0);
        chk("c_xfers",    32'(xfers),           DEPTH);
        chk("c_done_cnt", 32'(done_cnt),        1);
        chk("c_skin",     32'(bus.oSkin_count), DEPTH);

        // ---- Frame D: random map, random iReady ----
        for (int i = 0; i < DEPTH; i++) map_bits[i] = 1'($urandom_range(0, 1));
        pc = popcount_map();
        new_frame_model();
        cycle(1'b1, 1'b1);
        run_to_done(1'b1, -1, 1'b0);
        chk("d_xfers",    32'(xfers),           DEPTH);
        chk("d_issued",   32'(issued),          DEPTH);
        chk("d_done_cnt", 32'(done_cnt),        1);
        chk("d_skin",     32'(bus.oSkin_count), 32'(pc));

        // ---- Frame E: reset after transfer 500, then a full fresh frame ----
        new_frame_model();
        cycle(1'b1, 1'b1);
        for (int n = 0; n < 2000 && xfers < 500; n++) cycle(1'b0, 1'b1);
        chk("e_xfers_pre", 32'(xfers), 500);
        @(posedge iClk);
        #2;
        chk("e_busy_pre", 32'(bus.oBusy), 1);
        iReset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge iClk);
        iReset     = 1'b0;
        prev_valid = 1'b0;
        new_frame_model();
        repeat (5) begin
            cycle(1'b0, 1'b1);
            chk("post_rst_valid", 32'(bus.oValid),    0);
            chk("post_rst_rdreq", 32'(bus.oRdreq_SM), 0);
        end
        for (int i = 0; i < DEPTH; i++) map_bits[i] = 1'($urandom_range(0, 1));
        pc = popcount_map();
        new_frame_model();
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        chk("e_rdreq_first", 32'(bus.oRdreq_SM), 1);
        chk("e_addr_first",  32'(bus.oAddr_SM),  0);
        run_to_done(1'b0, -1, 1'b0);
        chk("e_xfers",    32'(xfers),           DEPTH);
        chk("e_issued",   32'(issued),          DEPTH);
        chk("e_done_cnt", 32'(done_cnt),        1);
        chk("e_skin",     32'(bus.oSkin_count), 32'(pc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
